id_ex_stage: RTL and testbench

ID/EX pipeline stage of the pipelined CPU, sitting directly upstream of the ALU. It registers decoded operands and control from ID and resolves EX/MEM and MEM/WB forwarding. It drives the ALU's A, B and ALUOp inputs. It also detects load-use hazards, inserts bubbles, and carries memory/write-back control and store data forward to EX/MEM.

---
 rtl/id_ex_stage_if.sv | 38 +++
 rtl/id_ex_stage.sv | 76 +++++++
 tb/tb_id_ex_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID/EX stage bus (ID operands and control, forwarding sources, ALU/EX outputs)
interface id_ex_stage_if #(
    parameter int W  = 32,
    parameter int RA = 5
);
    logic          hold, flush, id_valid;
    logic [W-1:0]  id_rs_data, id_rt_data, id_imm;
    logic [4:0]    id_shamt, id_alu_op;
    logic [RA-1:0] id_rs, id_rt, id_rd;
    logic          id_srca_shamt, id_srcb_imm;
    logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic          exm_reg_write, wb_reg_write;
    logic [RA-1:0] exm_rd, wb_rd;
    logic [W-1:0]  exm_result, wb_data;
    logic          load_use_stall;
    logic [W-1:0]  alu_a, alu_b, ex_store_data;
    logic [4:0]    alu_op;
    logic [RA-1:0] ex_rd;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    modport master (
        output hold, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_op,
               id_rs, id_rt, id_rd, id_srca_shamt, id_srcb_imm,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_data,
        input  load_use_stall, alu_a, alu_b, alu_op, ex_store_data, ex_rd,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );

    modport slave (
        input  hold, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_op,
               id_rs, id_rt, id_rd, id_srca_shamt, id_srcb_imm,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_data,
        output load_use_stall, alu_a, alu_b, alu_op, ex_store_data, ex_rd,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, ALU operand select and load-use bubbles
module id_ex_stage #(
    parameter int W  = 32,
    parameter int RA = 5
) (
    input logic          clk,
    input logic          rstn,
    id_ex_stage_if.slave bus
);
    logic          valid, reg_write, mem_read, mem_write, mem_to_reg, srca_shamt, srcb_imm;
    logic [W-1:0]  rs_data, rt_data, imm, fwd_rs, fwd_rt;
    logic [4:0]    shamt, alu_op;
    logic [RA-1:0] rs, rt, rd;
    logic          bubble;

    // A load in EX cannot supply its data to the instruction in ID until it reaches MEM/WB
    assign bus.load_use_stall = bus.id_valid & valid & mem_read & (rd != '0) &
                                ((rd == bus.id_rs) | (rd == bus.id_rt));
    assign bubble = bus.flush | bus.load_use_stall;

    // Stage register: reset clears, hold freezes, flush/stall inserts a bubble, else capture ID
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid      <= 1'b0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            srca_shamt <= 1'b0;
            srcb_imm   <= 1'b0;
            alu_op     <= '0;
            rs         <= '0;
            rt         <= '0;
            rd         <= '0;
            rs_data    <= '0;
            rt_data    <= '0;
            imm        <= '0;
            shamt      <= '0;
        end else if (!bus.hold) begin
            valid      <= !bubble & bus.id_valid;
            reg_write  <= !bubble & bus.id_reg_write;
            mem_read   <= !bubble & bus.id_mem_read;
            mem_write  <= !bubble & bus.id_mem_write;
            mem_to_reg <= !bubble & bus.id_mem_to_reg;
            alu_op     <= bubble ? '0 : bus.id_alu_op;
            rs         <= bubble ? '0 : bus.id_rs;
            rt         <= bubble ? '0 : bus.id_rt;
            rd         <= bubble ? '0 : bus.id_rd;
            srca_shamt <= bus.id_srca_shamt;
            srcb_imm   <= bus.id_srcb_imm;
            rs_data    <= bus.id_rs_data;
            rt_data    <= bus.id_rt_data;
            imm        <= bus.id_imm;
            shamt      <= bus.id_shamt;
        end
    end

    // Forwarding: EX/MEM beats MEM/WB, and register 0 is never forwarded
    always_comb begin
        fwd_rs = (bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == rs) ? bus.exm_result :
                 (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == rs) ? bus.wb_data : rs_data;
        fwd_rt = (bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == rt) ? bus.exm_result :
                 (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == rt) ? bus.wb_data : rt_data;
    end

    assign bus.alu_a         = srca_shamt ? {{(W-5){1'b0}}, shamt} : fwd_rs;
    assign bus.alu_b         = srcb_imm ? imm : fwd_rt;
    assign bus.ex_store_data = fwd_rt;
    assign bus.alu_op        = alu_op;
    assign bus.ex_rd         = rd;
    assign bus.ex_valid      = valid;
    assign bus.ex_reg_write  = reg_write;
    assign bus.ex_mem_read   = mem_read;
    assign bus.ex_mem_write  = mem_write;
    assign bus.ex_mem_to_reg = mem_to_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against an instruction-record model
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_bad = 0;

    id_ex_stage_if #(.W(32), .RA(5)) bus ();
    id_ex_stage #(.W(32), .RA(5)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rw, mr, mw, m2r, sa, sb;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  sh, op, rs, rt, rd;
    } rec_t;

    rec_t m;
    bit   known;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] d);
        if (bus.exm_reg_write && bus.exm_rd != 0 && bus.exm_rd == s) return bus.exm_result;
        if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == s) return bus.wb_data;
        return d;
    endfunction

    function automatic logic m_stall();
        return bus.id_valid && m.valid && m.mr && m.rd != 0 && (m.rd == bus.id_rs || m.rd == bus.id_rt);
    endfunction

    task automatic model_update();
        rec_t n;
        n.valid = bus.id_valid; n.rw = bus.id_reg_write; n.mr = bus.id_mem_read;
        n.mw = bus.id_mem_write; n.m2r = bus.id_mem_to_reg; n.sa = bus.id_srca_shamt;
        n.sb = bus.id_srcb_imm; n.rsd = bus.id_rs_data; n.rtd = bus.id_rt_data;
        n.imm = bus.id_imm; n.sh = bus.id_shamt; n.op = bus.id_alu_op;
        n.rs = bus.id_rs; n.rt = bus.id_rt; n.rd = bus.id_rd;
        if (!rstn) begin
            m = '{valid: 0, rw: 0, mr: 0, mw: 0, m2r: 0, sa: 0, sb: 0, rsd: 0, rtd: 0, imm: 0,
                  sh: 0, op: 0, rs: 0, rt: 0, rd: 0};
            known = 1;
        end else if (bus.hold) begin
        end else if (bus.flush || m_stall()) begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0;
            m.op = 0; m.rs = 0; m.rt = 0; m.rd = 0;
            known = 0;
        end else begin
            m = n;
            known = 1;
        end
    endtask

    task automatic check_all();
        chk("stall", 32'(bus.load_use_stall), 32'(m_stall()));
        chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
        chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.rw));
        chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
        chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(m.mw));
        chk("ex_mem_to_reg", 32'(bus.ex_mem_to_reg), 32'(m.m2r));
        chk("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
        chk("alu_op", 32'(bus.alu_op), 32'(m.op));
        if (known) begin
            chk("alu_a", bus.alu_a, m.sa ? 32'(m.sh) : fwd(m.rs, m.rsd));
            chk("alu_b", bus.alu_b, m.sb ? m.imm : fwd(m.rt, m.rtd));
            chk("store_data", bus.ex_store_data, fwd(m.rt, m.rtd));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic run_cycle();
        #1 check_all();
        tick();
    endtask

    task automatic idle();
        bus.hold = 0; bus.flush = 0; bus.id_valid = 0;
        bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0; bus.id_shamt = 0; bus.id_alu_op = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.id_srca_shamt = 0; bus.id_srcb_imm = 0;
        bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
        bus.exm_reg_write = 0; bus.exm_rd = 0; bus.exm_result = 0;
        bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_data = 0;
    endtask

    task automatic rand_inputs();
        bus.hold = $urandom_range(9) == 0; bus.flush = $urandom_range(9) == 0;
        bus.id_valid = $urandom_range(4) != 0;
        bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
        bus.id_shamt = 5'($urandom); bus.id_alu_op = 5'($urandom);
        bus.id_rs = 5'($urandom_range(3)); bus.id_rt = 5'($urandom_range(3)); bus.id_rd = 5'($urandom_range(3));
        bus.id_srca_shamt = $urandom_range(3) == 0; bus.id_srcb_imm = $urandom_range(2) == 0;
        bus.id_reg_write = $urandom_range(1) == 1; bus.id_mem_read = $urandom_range(2) == 0;
        bus.id_mem_write = $urandom_range(3) == 0; bus.id_mem_to_reg = $urandom_range(1) == 1;
        bus.exm_reg_write = $urandom_range(1) == 1; bus.exm_rd = 5'($urandom_range(3)); bus.exm_result = $urandom;
        bus.wb_reg_write = $urandom_range(1) == 1; bus.wb_rd = 5'($urandom_range(3)); bus.wb_data = $urandom;
    endtask

    initial begin
        rstn = 0;
        rand_inputs();
        @(negedge clk);
        // reset for two cycles with random ID inputs
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            tick();
        end
        rstn = 1;
        idle();
        #1;
        chk("rst_valid", 32'(bus.ex_valid), 0);
        chk("rst_rw", 32'(bus.ex_reg_write), 0);
        chk("rst_mr", 32'(bus.ex_mem_read), 0);
        chk("rst_rd", 32'(bus.ex_rd), 0);
        chk("rst_op", 32'(bus.alu_op), 0);
        chk("rst_stall", 32'(bus.load_use_stall), 0);
        chk("rst_a", bus.alu_a, 0);
        // plain ADD capture
        bus.id_valid = 1; bus.id_rs = 1; bus.id_rt = 2; bus.id_rd = 3;
        bus.id_rs_data = 5; bus.id_rt_data = 7; bus.id_alu_op = 5'h02; bus.id_reg_write = 1;
        run_cycle();
        idle();
        #1;
        chk("add_a", bus.alu_a, 5);
        chk("add_b", bus.alu_b, 7);
        chk("add_op", 32'(bus.alu_op), 2);
        chk("add_rw", 32'(bus.ex_reg_write), 1);
        // forwarding priority on rs=3
        bus.id_valid = 1; bus.id_rs = 3; bus.id_rs_data = 32'h99; bus.id_rd = 1; bus.id_reg_write = 1;
        run_cycle();
        idle();
        bus.hold = 1;
        bus.exm_reg_write = 1; bus.exm_rd = 3; bus.exm_result = 32'h11;
        bus.wb_reg_write = 1; bus.wb_rd = 3; bus.wb_data = 32'h22;
        #1 chk("fwd_exm", bus.alu_a, 32'h11);
        bus.exm_reg_write = 0;
        #1 chk("fwd_wb", bus.alu_a, 32'h22);
        run_cycle();
        idle();
        bus.id_valid = 1; bus.id_rs = 0; bus.id_rs_data = 32'h55;
        run_cycle();
        idle();
        bus.exm_reg_write = 1; bus.exm_rd = 0; bus.exm_result = 32'h11;
        bus.wb_reg_write = 1; bus.wb_rd = 0; bus.wb_data = 32'h22;
        #1 chk("fwd_r0", bus.alu_a, 32'h55);
        run_cycle();
        // load-use: LW r4 then ADD r5,r4,r4
        idle();
        bus.id_valid = 1; bus.id_rs = 1; bus.id_rd = 4; bus.id_mem_read = 1; bus.id_mem_to_reg = 1; bus.id_reg_write = 1;
        run_cycle();
        idle();
        bus.id_valid = 1; bus.id_rs = 4; bus.id_rt = 4; bus.id_rd = 5; bus.id_reg_write = 1; bus.id_alu_op = 5'h02;
        #1 chk("lu_stall_on", 32'(bus.load_use_stall), 1);
        run_cycle();
        #1 chk("lu_stall_off", 32'(bus.load_use_stall), 0);
        chk("lu_bubble", 32'(bus.ex_valid), 0);
        run_cycle();
        idle();
        bus.wb_reg_write = 1; bus.wb_rd = 4; bus.wb_data = 32'hDEAD;
        #1 chk("lu_a", bus.alu_a, 32'hDEAD);
        chk("lu_b", bus.alu_b, 32'hDEAD);
        chk("lu_valid", 32'(bus.ex_valid), 1);
        run_cycle();
        // shift amount and immediate selection
        idle();
        bus.id_valid = 1; bus.id_srca_shamt = 1; bus.id_shamt = 4; bus.id_srcb_imm = 1; bus.id_imm = 32'h0000ABCD;
        bus.id_rs = 1; bus.id_rs_data = 32'h1234; bus.id_rt = 2; bus.id_rt_data = 32'h77;
        run_cycle();
        idle();
        #1 chk("sh_a", bus.alu_a, 4);
        chk("imm_b", bus.alu_b, 32'h0000ABCD);
        chk("imm_store", bus.ex_store_data, 32'h77);
        // hold/flush interplay
        bus.id_valid = 1; bus.id_rd = 6; bus.id_reg_write = 1;
        run_cycle();
        bus.hold = 1; bus.flush = 1; bus.id_rd = 9;
        run_cycle();
        bus.hold = 0;
        #1 chk("hold_valid", 32'(bus.ex_valid), 1);
        chk("hold_rd", 32'(bus.ex_rd), 6);
        run_cycle();
        bus.flush = 0; bus.id_rd = 7;
        #1 chk("flush_valid", 32'(bus.ex_valid), 0);
        chk("flush_rd", 32'(bus.ex_rd), 0);
        run_cycle();
        idle();
        #1 chk("after_valid", 32'(bus.ex_valid), 1);
        chk("after_rd", 32'(bus.ex_rd), 7);
        run_cycle();
        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rstn = $urandom_range(39) != 0;
            rand_inputs();
            run_cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
